seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
//
// Sequential MIPS-style ALU with a three-state controller. Single-cycle
// operations (ADD, SUB, AND, OR, NOR, SLT) finish one edge after they are
// accepted. SLL runs on a bit-serial shifter and takes shamt+1 edges.
// Any unsupported operation code finishes in one edge with the illegal flag
// raised.
//
// Ports
//   clk        : single clock, every state change happens on its rising edge
//   reset_n    : synchronous active-low reset
//   start      : request to begin an operation (ignored while busy)
//   alucontrol : 4-bit operation code from the ALU control decoder
//   a, b       : WIDTH-bit operands (rs, rt)
//   shamt      : SHW-bit shift amount for SLL
//   busy       : high whenever the controller is not idle
//   done       : one-cycle completion pulse
//   result     : WIDTH-bit result, held until the next completion
//   zero       : result equals zero, held with result
//   overflow   : signed overflow on ADD/SUB, held with result
//   illegal    : unsupported operation code, held with result
// ---------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [3:0]       aluOp_q, aluOp_d;
  logic [WIDTH-1:0] accum_q, accum_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] aluRes;
  logic             aluOvf;
  logic             aluIll;

  // Single-cycle datapath working on the registered operands. SLL never
  // reaches EXEC, so its code falls into the illegal default harmlessly.
  // Signed overflow: ADD overflows when both operands share a sign that
  // the sum does not; SUB overflows when the operand signs differ and the
  // difference takes the sign of b.
  always_comb begin
    sum    = opA_q + opB_q;
    diff   = opA_q - opB_q;
    aluRes = '0;
    aluOvf = 1'b0;
    aluIll = 1'b0;
    case (aluOp_q)
      OP_ADD: begin
        aluRes = sum;
        aluOvf = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) &&
                 (sum[WIDTH-1] != opA_q[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes = diff;
        aluOvf = (opA_q[WIDTH-1] != opB_q[WIDTH-1]) &&
                 (diff[WIDTH-1] != opA_q[WIDTH-1]);
      end
      OP_AND: aluRes = opA_q & opB_q;
      OP_OR:  aluRes = opA_q | opB_q;
      OP_NOR: aluRes = ~(opA_q | opB_q);
      OP_SLT: aluRes[0] = ($signed(opA_q) < $signed(opB_q));
      default: aluIll = 1'b1;
    endcase
  end

  // Controller next-state logic. Operands are captured only at the
  // accepting edge in IDLE; SLL also preloads the accumulator with b and
  // the counter with shamt there, so the shifter spends exactly shamt
  // edges shifting plus one edge to publish the result.
  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    aluOp_d    = aluOp_q;
    accum_d    = accum_q;
    count_d    = count_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          opA_d   = a;
          opB_d   = b;
          aluOp_d = alucontrol;
          if (alucontrol == OP_SLL) begin
            accum_d = b;
            count_d = shamt;
            state_d = SHIFT;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        result_d   = aluRes;
        zero_d     = (aluRes == '0);
        overflow_d = aluOvf;
        illegal_d  = aluIll;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      SHIFT: begin
        if (count_q == '0) begin
          result_d   = accum_q;
          zero_d     = (accum_q == '0);
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          accum_d = {accum_q[WIDTH-2:0], 1'b0};
          count_d = count_q - SHW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset wins over everything, including a start in the
  // same cycle, and aborts any operation in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      aluOp_q    <= '0;
      accum_q    <= '0;
      count_q    <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      aluOp_q    <= aluOp_d;
      accum_q    <= accum_d;
      count_q    <= count_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      done_q     <= done_d;
    end
  end

  // busy comes straight from the state, so it is already low in the done
  // cycle and a new start there is accepted back-to-back.
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;
  assign illegal  = illegal_q;

endmodule
